// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one 32-bit ALU between two requesters (for example the integer pipe
// and the address-generation unit). Each requester has a valid/ready request
// channel and a valid/ready response channel. Only one operation is in flight
// at a time. It moves through three states:
//   IDLE : arbitrate and accept one request
//   EXEC : drive the ALU from the latched operands and capture its outputs
//   RESP : hold the response until the owning requester takes it
//
// Arbitration is round-robin. When both requesters are valid, the winner is
// the one that was not granted last. The last-grant pointer comes out of
// reset pointing at requester 1, so requester 0 wins the first tie.
//
// Optional feature (compile-time macro):
//   ALU_ARB_FIXED_PRIO_EN - requester 0 always wins ties and there is no
//                           last-grant pointer. Requester 1 can starve while
//                           req0_valid stays high.
//
// Ports:
//   clk, rst                      clock (rising edge) and async active-low reset
//   reqN_valid / reqN_ready       request handshake (ready is combinational)
//   reqN_src1, reqN_src2, reqN_op operands and opcode, sampled at the handshake
//   rspN_valid / rspN_ready       response handshake
//   rspN_result, rspN_zero        registered ALU result and Zero flag
//   alu_src1, alu_src2, alu_type  ALU operand and opcode inputs
//   alu_rst                       ALU reset input, held at 0 (ALU always enabled)
//   alu_result, alu_zero          ALU outputs
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DataSize  = 32,
    parameter int ALUopSize = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DataSize-1:0]  req0_src1,
    input  logic [DataSize-1:0]  req0_src2,
    input  logic [ALUopSize-1:0] req0_op,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DataSize-1:0]  req1_src1,
    input  logic [DataSize-1:0]  req1_src2,
    input  logic [ALUopSize-1:0] req1_op,

    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [DataSize-1:0]  rsp0_result,
    output logic                 rsp0_zero,

    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [DataSize-1:0]  rsp1_result,
    output logic                 rsp1_zero,

    output logic [DataSize-1:0]  alu_src1,
    output logic [DataSize-1:0]  alu_src2,
    output logic [ALUopSize-1:0] alu_type,
    output logic                 alu_rst,
    input  logic [DataSize-1:0]  alu_result,
    input  logic                 alu_zero
);

    localparam logic [ALUopSize-1:0] OP_XOR  = ALUopSize'(4);
    localparam logic [ALUopSize-1:0] OP_NDEF = ALUopSize'(8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    // Operation latched at the request handshake
    logic [DataSize-1:0]    src1_q;
    logic [DataSize-1:0]    src2_q;
    logic [ALUopSize-1:0]   op_q;
    logic                   owner_q;     // 0 = requester 0, 1 = requester 1

    // Response registers, written only on the EXEC->RESP edge
    logic [DataSize-1:0]    result_q;
    logic                   zero_q;

    logic                   any_req;
    logic                   grant;       // id of the requester that wins in IDLE
    logic                   accept;      // a handshake happens this cycle
    logic                   owner_rsp_ready;

    assign any_req         = req0_valid | req1_valid;
    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    // ------------------------------------------------------------------
    // Winner selection. A lone requester always wins. A tie is broken by
    // the last-grant pointer, or by fixed priority when that build option
    // is enabled.
    // ------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = 1'b0;
        if (!req0_valid && req1_valid) begin
            grant = 1'b1;
        end
    end
`else
    logic last_q;                        // requester granted most recently

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Reset value 1 makes requester 0 the winner of the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant;
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs. Ready depends on rst so that a requester
    // holding valid during reset never sees a handshake.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        alu_type   = op_q;

        case (state)
            IDLE: begin
                // No operation is in flight, so the ALU sees the NDEF opcode
                alu_type = OP_NDEF;
                if (any_req && rst) begin
                    accept     = 1'b1;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = ~owner_q;
                rsp1_valid = owner_q;
                if (owner_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                alu_type  = OP_NDEF;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch. The ALU inputs come straight from these registers, so
    // they stay stable through EXEC and RESP and only change on a new
    // handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src1_q  <= '0;
            src2_q  <= '0;
            op_q    <= OP_NDEF;
            owner_q <= 1'b0;
        end else if (accept) begin
            src1_q  <= grant ? req1_src1 : req0_src1;
            src2_q  <= grant ? req1_src2 : req0_src2;
            op_q    <= grant ? req1_op   : req0_op;
            owner_q <= grant;
        end
    end

    // ------------------------------------------------------------------
    // Result capture at the end of EXEC. Opcodes of 8 and above always
    // return zero, whatever the ALU drives for them. The ALU Zero output is
    // meaningful only for XOR, so it is masked for every other opcode.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (state == EXEC) begin
            result_q <= (op_q < OP_NDEF) ? alu_result : '0;
            zero_q   <= (op_q == OP_XOR) ? alu_zero : 1'b0;
        end
    end

    // The response data is shared. Only the owner's rsp_valid qualifies it.
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;

    // Shift amounts go through unmodified; the ALU applies the mod-32 rule
    assign alu_src1 = src1_q;
    assign alu_src2 = src2_q;
    assign alu_rst  = 1'b0;

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [3:0]  alu_type;
    logic        alu_rst, alu_zero;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DataSize(32), .ALUopSize(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_type(alu_type),
        .alu_rst(alu_rst), .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Stand-in ALU. Undefined opcodes return junk, and Zero is raised for any
    // zero result, so the arbiter's masking is what the checks exercise.
    always_comb begin
        alu_result = 32'hDEADBEEF;
        case (alu_type)
            4'd0: alu_result = alu_src1 + alu_src2;
            4'd1: alu_result = alu_src1 - alu_src2;
            4'd2: alu_result = alu_src1 << alu_src2[4:0];
            4'd3: alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
            4'd4: alu_result = alu_src1 ^ alu_src2;
            4'd5: alu_result = alu_src1 >> alu_src2[4:0];
            4'd6: alu_result = alu_src1 | alu_src2;
            4'd7: alu_result = alu_src1 & alu_src2;
            default: ;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    // Expected response {zero, result} for one operation
    function automatic logic [32:0] ref_rsp(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a << b[4:0];
            4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: r = a ^ b;
            4'd5: r = a >> b[4:0];
            4'd6: r = a | b;
            4'd7: r = a & b;
            default: r = 32'd0;
        endcase
        return {(op == 4'd4) && (r == 32'd0), r};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        req0_src1 = 0; req0_src2 = 0; req0_op = 0;
        req1_src1 = 0; req1_src2 = 0; req1_op = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one operation through the DUT with both rsp_ready high.
    // lat counts negedges from the handshake cycle to the first rsp_valid.
    task automatic run_op(input bit who, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output logic z,
                          output int lat, output logic [3:0] exec_type, output bit other_v);
        int n = 0;
        bit done = 0;
        other_v = 0; lat = 0; res = 'x; z = 'x; exec_type = 'x;
        @(posedge clk); #1;
        if (who) begin req1_valid = 1; req1_src1 = a; req1_src2 = b; req1_op = op; end
        else     begin req0_valid = 1; req0_src1 = a; req0_src2 = b; req0_op = op; end
        @(negedge clk);
        while (!(who ? req1_ready : req0_ready) && n < 20) begin n++; @(negedge clk); end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        if (n >= 20) begin lat = -1; return; end
        while (!done && lat < 20) begin
            @(negedge clk); lat++;
            if (lat == 1) exec_type = alu_type;
            if (who ? rsp0_valid : rsp1_valid) other_v = 1;
            if (who ? rsp1_valid : rsp0_valid) begin
                res  = who ? rsp1_result : rsp0_result;
                z    = who ? rsp1_zero : rsp0_zero;
                done = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
        req0_src1 = 1; req0_src2 = 2; req0_op = 0;
        req1_src1 = 3; req1_src2 = 4; req1_op = 1;
        @(negedge clk);
        vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin miscompares++;
            $display("FAIL reset_req_ready: got %b expected 00", {req0_ready, req1_ready}); end
        vectors++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin miscompares++;
            $display("FAIL reset_rsp_valid: got %b expected 00", {rsp0_valid, rsp1_valid}); end
        vectors++; if ({rsp0_result, rsp1_result, rsp0_zero, rsp1_zero} !== 66'd0) begin miscompares++;
            $display("FAIL reset_rsp_data: got %h %h %b %b expected zeros", rsp0_result, rsp1_result, rsp0_zero, rsp1_zero); end
        vectors++; if ({alu_src1, alu_src2} !== 64'd0) begin miscompares++;
            $display("FAIL reset_alu_src: got %h %h expected 0 0", alu_src1, alu_src2); end
        vectors++; if (alu_type !== 4'd8) begin miscompares++;
            $display("FAIL reset_alu_type: got %0d expected 8", alu_type); end
        vectors++; if (alu_rst !== 1'b0) begin miscompares++;
            $display("FAIL reset_alu_rst: got %b expected 0", alu_rst); end
        do_reset();
    endtask

    task automatic test_single();
        logic [31:0] r; logic z; int lat; logic [3:0] et; bit ov;
        run_op(0, 4'd0, 32'd5, 32'd7, r, z, lat, et, ov);
        vectors++; if (lat !== 2) begin miscompares++;
            $display("FAIL single_latency: got %0d expected 2", lat); end
        vectors++; if (r !== 32'd12) begin miscompares++;
            $display("FAIL single_result: got %0d expected 12", r); end
        vectors++; if (z !== 1'b0) begin miscompares++;
            $display("FAIL single_zero: got %b expected 0", z); end
        vectors++; if (ov !== 1'b0) begin miscompares++;
            $display("FAIL single_rsp1_valid: got %b expected 0", ov); end
        vectors++; if (et !== 4'd0) begin miscompares++;
            $display("FAIL single_exec_alu_type: got %0d expected 0", et); end
    endtask

    task automatic test_zero_flag();
        logic [3:0] ops[3]; logic [31:0] as[3], bs[3], er[3]; logic ez[3];
        logic [31:0] r; logic z; int lat; logic [3:0] et; bit ov;
        ops = '{4'd4, 4'd1, 4'd4};
        as  = '{32'hA5A5A5A5, 32'd3, 32'hA5A5A5A5};
        bs  = '{32'hA5A5A5A5, 32'd3, 32'h5A5A5A5A};
        er  = '{32'd0, 32'd0, 32'hFFFFFFFF};
        ez  = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_op(1, ops[i], as[i], bs[i], r, z, lat, et, ov);
            vectors++; if (lat !== 2 || ov !== 1'b0) begin miscompares++;
                $display("FAIL zero_handshake[%0d]: got lat=%0d rsp0_valid_seen=%b expected lat=2 seen=0", i, lat, ov); end
            vectors++; if (r !== er[i]) begin miscompares++;
                $display("FAIL zero_result[%0d]: got %h expected %h", i, r, er[i]); end
            vectors++; if (z !== ez[i]) begin miscompares++;
                $display("FAIL zero_flag[%0d]: got %b expected %b", i, z, ez[i]); end
        end
    endtask

    task automatic test_edge_ops();
        logic [3:0] ops[5]; logic [31:0] as[5], bs[5], er[5];
        logic [31:0] r; logic z; int lat; logic [3:0] et; bit ov;
        ops = '{4'd2, 4'd3, 4'd5, 4'd9, 4'd15};
        as  = '{32'd1, 32'd2, 32'h80000000, 32'd5, 32'd0};
        bs  = '{32'd33, 32'd9, 32'd35, 32'd6, 32'd0};
        er  = '{32'd2, 32'd1, 32'h10000000, 32'd0, 32'd0};
        for (int i = 0; i < 5; i++) begin
            run_op(i[0], ops[i], as[i], bs[i], r, z, lat, et, ov);
            vectors++; if (lat !== 2 || ov !== 1'b0) begin miscompares++;
                $display("FAIL edge_handshake[%0d]: got lat=%0d other_seen=%b expected lat=2 seen=0", i, lat, ov); end
            vectors++; if (r !== er[i] || z !== 1'b0) begin miscompares++;
                $display("FAIL edge_result[%0d]: got %h/%b expected %h/0", i, r, z, er[i]); end
            vectors++; if (et !== ops[i]) begin miscompares++;
                $display("FAIL edge_exec_alu_type[%0d]: got %0d expected %0d", i, et, ops[i]); end
        end
    endtask

    task automatic test_contention();
        logic [3:0] op0[4], op1[4]; logic [31:0] a0[4], b0[4], a1[4], b1[4];
        logic [32:0] e0[$], e1[$], ex;
        int grants[$]; int exp_g[8];
        int i0 = 0, i1 = 0, got0 = 0, got1 = 0, cyc = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            op0[i] = 4'($urandom_range(0, 7)); a0[i] = $urandom; b0[i] = $urandom;
            op1[i] = 4'($urandom_range(0, 7)); a1[i] = $urandom; b1[i] = $urandom;
        end
        while ((got0 < 4 || got1 < 4) && cyc < 200) begin
            @(posedge clk); #1;
            req0_valid = (i0 < 4);
            if (i0 < 4) begin req0_op = op0[i0]; req0_src1 = a0[i0]; req0_src2 = b0[i0]; end
            req1_valid = (i1 < 4);
            if (i1 < 4) begin req1_op = op1[i1]; req1_src1 = a1[i1]; req1_src2 = b1[i1]; end
            @(negedge clk); cyc++;
            if (rsp0_valid) begin
                ex = (e0.size() > 0) ? e0.pop_front() : 33'bx;
                vectors++; if ({rsp0_zero, rsp0_result} !== ex) begin miscompares++;
                    $display("FAIL contention_rsp0[%0d]: got %h expected %h", got0, {rsp0_zero, rsp0_result}, ex); end
                got0++;
            end
            if (rsp1_valid) begin
                ex = (e1.size() > 0) ? e1.pop_front() : 33'bx;
                vectors++; if ({rsp1_zero, rsp1_result} !== ex) begin miscompares++;
                    $display("FAIL contention_rsp1[%0d]: got %h expected %h", got1, {rsp1_zero, rsp1_result}, ex); end
                got1++;
            end
            if (req0_valid && req0_ready) begin
                grants.push_back(0); e0.push_back(ref_rsp(op0[i0], a0[i0], b0[i0])); i0++;
            end
            if (req1_valid && req1_ready) begin
                grants.push_back(1); e1.push_back(ref_rsp(op1[i1], a1[i1], b1[i1])); i1++;
            end
        end
        req0_valid = 0; req1_valid = 0;
        vectors++; if (cyc >= 200) begin miscompares++;
            $display("FAIL contention_timeout: got %0d/%0d responses expected 4/4", got0, got1); end
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (k >= grants.size() || grants[k] !== exp_g[k]) begin miscompares++;
                $display("FAIL contention_grant[%0d]: got %0d expected %0d", k,
                         (k < grants.size()) ? grants[k] : -1, exp_g[k]); end
        end
    endtask

    task automatic test_backpressure();
        int n = 0; bit bad = 0;
        @(posedge clk); #1;
        rsp0_ready = 0; req0_valid = 1; req0_op = 4'd0; req0_src1 = 32'd100; req0_src2 = 32'd23;
        @(negedge clk);
        while (!req0_ready && n < 20) begin n++; @(negedge clk); end
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 1; req1_op = 4'd4; req1_src1 = 32'h1234; req1_src2 = 32'h1234;
        n = 0;
        @(negedge clk);
        while (!rsp0_valid && n < 20) begin if (req1_ready) bad = 1; n++; @(negedge clk); end
        vectors++; if (n >= 20 || bad) begin miscompares++;
            $display("FAIL bp_first_rsp: got wait=%0d req1_ready_seen=%b expected rsp0 and no grant", n, bad); end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({rsp0_valid, rsp0_result, rsp0_zero, req1_ready, rsp1_valid} !== {1'b1, 32'd123, 1'b0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%0d z=%b req1_ready=%b rsp1_valid=%b expected 1 123 0 0 0",
                         k, rsp0_valid, rsp0_result, rsp0_zero, req1_ready, rsp1_valid);
            end
            @(negedge clk);
        end
        @(posedge clk); #1; rsp0_ready = 1;
        @(negedge clk);
        vectors++; if (req1_ready !== 1'b0 || rsp0_valid !== 1'b1) begin miscompares++;
            $display("FAIL bp_release: got req1_ready=%b rsp0_valid=%b expected 0 1", req1_ready, rsp0_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if ({req1_ready, req0_ready, rsp0_valid} !== 3'b100) begin miscompares++;
            $display("FAIL bp_next_grant: got req1_ready=%b req0_ready=%b rsp0_valid=%b expected 1 0 0",
                     req1_ready, req0_ready, rsp0_valid); end
        @(posedge clk); #1; req1_valid = 0;
        n = 0;
        @(negedge clk);
        while (!rsp1_valid && n < 20) begin n++; @(negedge clk); end
        vectors++; if (n >= 20 || rsp1_result !== 32'd0 || rsp1_zero !== 1'b1) begin miscompares++;
            $display("FAIL bp_req1_rsp: got wait=%0d r=%h z=%b expected 0 and 1", n, rsp1_result, rsp1_zero); end
    endtask

    task automatic test_reset_midop();
        int n = 0; bit seen = 0;
        @(posedge clk); #1;
        req0_valid = 1; req0_op = 4'd0; req0_src1 = 32'd40; req0_src2 = 32'd2;
        @(negedge clk);
        while (!req0_ready && n < 20) begin n++; @(negedge clk); end
        @(posedge clk); #1;
        req0_valid = 0;
        #2 rst = 1'b0;
        #1;
        vectors++; if (n >= 20 || alu_type !== 4'd8) begin miscompares++;
            $display("FAIL midreset_alu_type: got %0d expected 8", alu_type); end
        vectors++; if ({rsp0_valid, rsp1_valid, rsp0_result} !== 34'd0) begin miscompares++;
            $display("FAIL midreset_rsp: got v=%b%b r=%h expected 00 0", rsp0_valid, rsp1_valid, rsp0_result); end
        @(negedge clk); rst = 1'b1;
        repeat (3) begin @(negedge clk); if (rsp0_valid || rsp1_valid) seen = 1; end
        vectors++; if (seen !== 1'b0) begin miscompares++;
            $display("FAIL midreset_no_rsp: got rsp_valid seen=%b expected 0", seen); end
        @(posedge clk); #1;
        req0_valid = 1; req1_valid = 1; req1_op = 4'd6;
        @(negedge clk);
        vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++;
            $display("FAIL midreset_first_grant: got req0_ready=%b req1_ready=%b expected 1 0", req0_ready, req1_ready); end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int last = 1; bit busy = 0; int age = 0; bit owner = 0;
        bit hs0 = 0, hs1 = 0;
        logic [32:0] exp_rsp = 0; logic [3:0] exp_op = 0; logic [1:0] er;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (hs0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_op = 4'($urandom_range(0, 10)); req0_src1 = $urandom;
                req0_src2 = ($urandom_range(0, 3) == 0) ? req0_src1 : $urandom;
            end else if ($urandom_range(0, 15) == 0) req0_valid = 0;
            if (hs1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_op = 4'($urandom_range(0, 10)); req1_src1 = $urandom;
                req1_src2 = ($urandom_range(0, 3) == 0) ? req1_src1 : $urandom;
            end else if ($urandom_range(0, 15) == 0) req1_valid = 0;
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            if (!busy) begin
                if (!req0_valid && !req1_valid) er = 2'b00;
                else if (!req1_valid)            er = 2'b01;
                else if (!req0_valid)            er = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
                else                             er = 2'b01;
`else
                else                             er = (last == 0) ? 2'b10 : 2'b01;
`endif
                vectors++; if ({req1_ready, req0_ready} !== er) begin miscompares++;
                    $display("FAIL rand_grant@%0d: got %b expected %b", cyc, {req1_ready, req0_ready}, er); end
                vectors++; if ({rsp1_valid, rsp0_valid} !== 2'b00 || alu_type !== 4'd8) begin miscompares++;
                    $display("FAIL rand_idle@%0d: got rsp_valid=%b alu_type=%0d expected 00 8", cyc, {rsp1_valid, rsp0_valid}, alu_type); end
                if (hs0 || hs1) begin
                    owner = hs1; busy = 1; age = 0; last = owner ? 1 : 0;
                    exp_op  = owner ? req1_op : req0_op;
                    exp_rsp = owner ? ref_rsp(req1_op, req1_src1, req1_src2)
                                    : ref_rsp(req0_op, req0_src1, req0_src2);
                end
            end else begin
                age++;
                vectors++; if ({req1_ready, req0_ready} !== 2'b00 || alu_type !== exp_op) begin miscompares++;
                    $display("FAIL rand_busy@%0d: got ready=%b alu_type=%0d expected 00 %0d", cyc, {req1_ready, req0_ready}, alu_type, exp_op); end
                if (age == 1) begin
                    vectors++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin miscompares++;
                        $display("FAIL rand_exec_rsp@%0d: got %b expected 00", cyc, {rsp1_valid, rsp0_valid}); end
                end else begin
                    vectors++;
                    if ({rsp1_valid, rsp0_valid} !== (owner ? 2'b10 : 2'b01) ||
                        {owner ? rsp1_zero : rsp0_zero, owner ? rsp1_result : rsp0_result} !== exp_rsp) begin
                        miscompares++;
                        $display("FAIL rand_rsp@%0d: got v=%b data=%h expected owner %0d data=%h", cyc,
                                 {rsp1_valid, rsp0_valid},
                                 {owner ? rsp1_zero : rsp0_zero, owner ? rsp1_result : rsp0_result}, owner, exp_rsp);
                    end
                    if (owner ? rsp1_ready : rsp0_ready) busy = 0;
                end
            end
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_zero_flag();
        test_edge_ops();
        test_backpressure();
        test_reset_midop();
        test_contention();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
